// File: rtl/mxv_pkg.sv
// Shared MxV datapath definitions: load FSM states and selector index constants.
// Also imported by the FIFO selector stage.
package mxv_pkg;

  localparam int DATA_W = 8;
  localparam int MAX_N  = 8;

  localparam logic [3:0] VEC_SEL  = 4'd8;
  localparam logic [3:0] NONE_SEL = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_MAT,
    LOAD_VEC,
    DONE
  } state_t;

endpackage

// File: rtl/mxv_elem_counter.sv
// Row/column element counter for the MxV load sequencer.
// Walks row-major: column wraps at n_last and carries into row.
module mxv_elem_counter #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] n_last,
  output logic [IDX_W-1:0] row,
  output logic             last_col,
  output logic             last_elem
);

  logic [IDX_W-1:0] col;

  assign last_col  = (col == n_last);
  assign last_elem = last_col && (row == n_last);

  // Clear on load start; advance one element per accepted byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (last_col) begin
        col <= '0;
        row <= row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mxv_load_sequencer.sv
// MxV load sequencer: tags a raw byte stream with row-FIFO / vector-FIFO
// destinations (N*N matrix bytes row-major, then N vector bytes) and drives
// a registered {i_sel, data_out, push_out} triple into the FIFO selector.
// Optional idle-abort: define MXV_LOAD_TIMEOUT_EN (adds err_timeout port).
module mxv_load_sequencer #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 8,
`ifdef MXV_LOAD_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 1024,
`endif
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_size,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [IDX_W-1:0]  i_sel,
  output logic [DATA_W-1:0] data_out,
  output logic              push_out,
  output logic              busy,
  output logic              load_done,
  output logic              err_size
`ifdef MXV_LOAD_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  import mxv_pkg::*;

  state_t            state, state_d;
  logic [IDX_W-1:0]  n_reg, n_d;
  logic [IDX_W-1:0]  sel_d;
  logic [DATA_W-1:0] data_d;
  logic              push_d, busy_d, done_d, err_d;
  logic              cnt_clr, cnt_inc;
  logic [IDX_W-1:0]  row;
  logic              last_col, last_elem;

  mxv_elem_counter #(.IDX_W(IDX_W)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .n_last    (n_reg - IDX_W'(1)),
    .row       (row),
    .last_col  (last_col),
    .last_elem (last_elem)
  );

`ifdef MXV_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          to_d;
  logic          in_load;

  assign in_load = (state == LOAD_MAT) || (state == LOAD_VEC);

  // Consecutive idle cycles while loading; restarts on each byte and each new load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (cnt_clr || rx_valid) begin
      idle_cnt <= '0;
    end else if (in_load) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d = state;
    n_d     = n_reg;
    sel_d   = IDX_W'(NONE_SEL);
    data_d  = data_out;
    push_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef MXV_LOAD_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if ((n_size != '0) && (n_size <= IDX_W'(MAX_N))) begin
            n_d     = n_size;
            cnt_clr = 1'b1;
            state_d = LOAD_MAT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_MAT: begin
        if (rx_valid) begin
          push_d  = 1'b1;
          sel_d   = row;
          data_d  = rx_data;
          cnt_inc = 1'b1;
          // Counter wraps col to 0 on the last element, ready for the vector phase.
          if (last_elem) state_d = LOAD_VEC;
        end
      end
      LOAD_VEC: begin
        if (rx_valid) begin
          push_d  = 1'b1;
          sel_d   = IDX_W'(VEC_SEL);
          data_d  = rx_data;
          cnt_inc = 1'b1;
          if (last_col) state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef MXV_LOAD_TIMEOUT_EN
    if (in_load && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1))) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end
`endif
    busy_d = (state_d == LOAD_MAT) || (state_d == LOAD_VEC);
  end

  // State, latched N and registered output triple/status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_reg     <= '0;
      i_sel     <= IDX_W'(NONE_SEL);
      data_out  <= '0;
      push_out  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      err_size  <= 1'b0;
    end else begin
      state     <= state_d;
      n_reg     <= n_d;
      i_sel     <= sel_d;
      data_out  <= data_d;
      push_out  <= push_d;
      busy      <= busy_d;
      load_done <= done_d;
      err_size  <= err_d;
    end
  end

`ifdef MXV_LOAD_TIMEOUT_EN
  // One-cycle abort pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_timeout <= 1'b0;
    else       err_timeout <= to_d;
  end
`endif

endmodule

// File: tb/tb_mxv_load_sequencer.sv
// Scoreboard bench for mxv_load_sequencer. Reference model: the k-th accepted
// byte of a load of size N goes to row k/N while k < N*N, else to the vector
// FIFOs; the load ends after N*N+N bytes. Honors MXV_LOAD_TIMEOUT_EN.
module tb_mxv_load_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, rx_valid;
  logic [3:0] n_size;
  logic [7:0] rx_data;
  logic [3:0] i_sel;
  logic [7:0] data_out;
  logic       push_out, busy, load_done, err_size;
`ifdef MXV_LOAD_TIMEOUT_EN
  logic       err_timeout;
  localparam int TO = 16;
`endif

`ifdef MXV_LOAD_TIMEOUT_EN
  mxv_load_sequencer #(.DATA_W(8), .MAX_N(8), .TIMEOUT_CYC(TO), .IDX_W(4)) dut (
`else
  mxv_load_sequencer #(.DATA_W(8), .MAX_N(8), .IDX_W(4)) dut (
`endif
    .clk(clk), .reset(reset), .start(start), .n_size(n_size),
    .rx_data(rx_data), .rx_valid(rx_valid), .i_sel(i_sel),
    .data_out(data_out), .push_out(push_out), .busy(busy),
    .load_done(load_done), .err_size(err_size)
`ifdef MXV_LOAD_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int         t;
    logic [3:0] sel;
    logic [7:0] d;
  } push_t;

  push_t pq[$];
  int    dq[$], eq[$], tq[$];
  bit    exp_busy [0:16383];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: 0 idle, 1 loading, 2 done cycle.
  int ph = 0, mn = 0, mk = 0, midle = 0;

  task automatic chk(input bit ok, input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Drive one cycle of inputs and record what the DUT must show afterwards.
  task automatic step(input bit r, input bit st, input logic [3:0] n, input bit v, input logic [7:0] d);
    int nph;
    push_t e;
    reset = r; start = st; n_size = n; rx_valid = v; rx_data = d;
    nph = ph;
    if (r) begin
      pq.delete(); dq.delete(); eq.delete(); tq.delete();
      exp_busy[cyc] = 1'b0;
      nph = 0;
    end else begin
      case (ph)
        0: if (st) begin
          if (n >= 1 && n <= 8) begin
            mn = int'(n); mk = 0; midle = 0; nph = 1;
          end else eq.push_back(cyc + 1);
        end
        1: begin
          if (v) begin
            e.t   = cyc + 1;
            e.sel = (mk < mn * mn) ? 4'(mk / mn) : 4'd8;
            e.d   = d;
            pq.push_back(e);
            mk++;
            midle = 0;
            if (mk == mn * mn + mn) nph = 2;
          end else begin
`ifdef MXV_LOAD_TIMEOUT_EN
            midle++;
            if (midle == TO) begin
              nph = 0;
              tq.push_back(cyc + 1);
            end
`endif
          end
        end
        default: begin
          dq.push_back(cyc + 1);
          nph = 0;
        end
      endcase
    end
    exp_busy[cyc + 1] = (nph == 1);
    ph = nph;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int unsigned k);
    for (int unsigned i = 0; i < k; i++)
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 8'($urandom));
  endtask

  // Monitor: compare DUT outputs against scoreboard every cycle.
  push_t e_m;
  bit    ep, ed, ee, et;
  always @(negedge clk) begin
    ep = (pq.size() > 0) && (pq[0].t == cyc);
    chk(push_out === ep, "push_out", push_out, ep);
    if (ep) begin
      e_m = pq.pop_front();
      chk(i_sel === e_m.sel, "push_sel", i_sel, e_m.sel);
      chk(data_out === e_m.d, "push_data", data_out, e_m.d);
    end else begin
      chk(i_sel === 4'd15, "idle_sel", i_sel, 15);
    end
    ed = (dq.size() > 0) && (dq[0] == cyc);
    if (ed) void'(dq.pop_front());
    chk(load_done === ed, "load_done", load_done, ed);
    ee = (eq.size() > 0) && (eq[0] == cyc);
    if (ee) void'(eq.pop_front());
    chk(err_size === ee, "err_size", err_size, ee);
    chk(busy === exp_busy[cyc], "busy", busy, exp_busy[cyc]);
    if (reset) chk(data_out === 8'h00, "reset_data", data_out, 0);
    et = (tq.size() > 0) && (tq[0] == cyc);
    if (et) void'(tq.pop_front());
`ifdef MXV_LOAD_TIMEOUT_EN
    chk(err_timeout === et, "err_timeout", err_timeout, et);
`endif
  end

  int budget;

  initial begin
    reset = 1'b1; start = 1'b0; n_size = '0; rx_valid = 1'b0; rx_data = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);

    // N=2 back-to-back directed load.
    step(1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    step(1'b0, 1'b0, 4'd2, 1'b1, 8'h11);
    step(1'b0, 1'b0, 4'd2, 1'b1, 8'h12);
    step(1'b0, 1'b0, 4'd2, 1'b1, 8'h21);
    step(1'b0, 1'b0, 4'd2, 1'b1, 8'h22);
    step(1'b0, 1'b0, 4'd2, 1'b1, 8'hA1);
    step(1'b0, 1'b0, 4'd2, 1'b1, 8'hA2);
    idle_steps(4);

    // Illegal sizes; bytes in IDLE dropped.
    step(1'b0, 1'b1, 4'd0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 4'd0, 1'b1, 8'h55);
    step(1'b0, 1'b1, 4'd9, 1'b1, 8'h66);
    idle_steps(3);

    // N=8 with random gaps.
    step(1'b0, 1'b1, 4'd8, 1'b0, 8'h00);
    for (int i = 0; i < 72; i++) begin
      if ($urandom_range(0, 1) == 0) idle_steps($urandom_range(1, 4));
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b1, 8'($urandom));
    end
    idle_steps(4);

    // Reset after 5 of 12 bytes, then a fresh N=1 load.
    step(1'b0, 1'b1, 4'd3, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd3, 1'b1, 8'(8'h30 + i));
    step(1'b1, 1'b0, 4'd3, 1'b1, 8'h99);
    step(1'b1, 1'b0, 4'd3, 1'b0, 8'h00);
    step(1'b0, 1'b1, 4'd1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 4'd1, 1'b1, 8'hC1);
    step(1'b0, 1'b0, 4'd1, 1'b1, 8'hC2);
    idle_steps(3);

    // start re-pulsed mid-load and in the DONE cycle: both ignored.
    step(1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, (i == 2), 4'd4, 1'b1, 8'(8'hD0 + i));
    step(1'b0, 1'b1, 4'd3, 1'b0, 8'h00);
    idle_steps(3);

    // Random loads, including illegal sizes.
    for (int l = 0; l < 6; l++) begin
      step(1'b0, 1'b1, 4'($urandom_range(0, 10)), 1'b0, 8'h00);
      budget = 400;
      while (ph != 0 && budget > 0) begin
        step(1'b0, 1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0), 8'($urandom));
        budget--;
      end
      chk(budget > 0, "load_budget", budget, 1);
      idle_steps(2);
    end

`ifdef MXV_LOAD_TIMEOUT_EN
    // Stall mid-load until abort.
    step(1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd2, 1'b1, 8'(8'hE0 + i));
    idle_steps(20);
    chk(ph == 0, "timeout_model_idle", ph, 0);
`endif

    idle_steps(3);
    chk(pq.size() == 0, "pending_pushes", pq.size(), 0);
    chk(dq.size() == 0, "pending_done", dq.size(), 0);
    chk(eq.size() == 0, "pending_err", eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mxv_load_sequencer.md
Name: mxv_load_sequencer

Overview:
- Upstream feeder of the FIFO selector stage in the MxV (matrix × vector) datapath.
- Takes a raw byte stream (e.g. UART RX) and tags each byte with a destination index: row FIFO 0..N-1, or the vector FIFOs (index 8).
- Counts row-major matrix elements, then vector elements, and drives a registered {i_sel, data_out, push_out} triple straight into the selector.
- Signals completion or size error to the top-level controller.

Parameters:
- DATA_W, 8, byte width of stream and FIFO data.
- MAX_N, 8, largest supported matrix dimension; equals the number of row FIFOs.
- IDX_W, 4, width of the selector index.
- TIMEOUT_CYC, 1024, idle cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- n_size  in  IDX_W  matrix dimension N, legal 1..MAX_N; latched on accepted start.
- rx_data  in  DATA_W  incoming byte.
- rx_valid  in  1  rx_data valid this cycle; no backpressure, every valid byte in a load state is consumed.
- i_sel  out  IDX_W  selector index: 0..N-1 = row FIFO, 8 = vector FIFOs, 15 = none.
- data_out  out  DATA_W  registered copy of the accepted byte.
- push_out  out  1  one-cycle push qualifying data_out/i_sel.
- busy  out  1  high in LOAD_MAT and LOAD_VEC.
- load_done  out  1  one-cycle pulse after the last vector byte is pushed.
- err_size  out  1  one-cycle pulse when start arrives with illegal n_size.

Behaviour:
- Reset values: i_sel=15, data_out=0, push_out=0, busy=0, load_done=0, err_size=0; FSM=IDLE; row=col=0; N register=0.
- States: IDLE, LOAD_MAT, LOAD_VEC, DONE.
- IDLE:
  - start with 1≤n_size≤MAX_N: latch N, clear row/col, go to LOAD_MAT.
  - start with n_size=0 or n_size>MAX_N: err_size=1 next cycle, stay in IDLE.
  - rx_valid is ignored (byte dropped).
- LOAD_MAT, on rx_valid:
  - Next cycle: data_out=rx_data, i_sel=row, push_out=1. Latency is exactly 1 cycle.
  - If col==N-1: col←0 and row←row+1; otherwise col←col+1.
  - When row==N-1 and col==N-1: go to LOAD_VEC with col←0.
- LOAD_VEC, on rx_valid:
  - Next cycle: data_out=rx_data, i_sel=8, push_out=1.
  - col increments; at col==N-1, go to DONE.
- DONE: load_done=1 for one cycle, then IDLE. Final push and load_done are on consecutive cycles (push first).
- Without rx_valid:
  - push_out=0 and i_sel=15 the following cycle; data_out holds its last value.
  - rx_valid gaps of any length are legal.
- start while busy or in DONE is ignored; n_size changes mid-load have no effect.
- Total pushes per load = N*N + N. Rows ≥ N are never selected.
- Counters are IDX_W wide; no wrap beyond N-1 is reachable.
- Reset mid-load: all state returns to reset values immediately; no further pushes; partially filled FIFOs are the downstream's responsibility.
- busy is a registered decode of state and is high from the cycle after an accepted start until DONE.

Optional Feature:
- Macro: MXV_LOAD_TIMEOUT_EN.
- With the macro defined:
  - Add output err_timeout (1 bit) and an idle-cycle counter that clears on every rx_valid and on entering LOAD_MAT.
  - If TIMEOUT_CYC consecutive cycles pass in LOAD_MAT/LOAD_VEC without rx_valid: return to IDLE, pulse err_timeout for 1 cycle, no load_done.
- Without the macro: no port, no counter; the block waits indefinitely.

Decomposition:
- Shared package mxv_pkg:
  - state enum (IDLE, LOAD_MAT, LOAD_VEC, DONE);
  - constants VEC_SEL=4'd8, NONE_SEL=4'd15, MAX_N=8, DATA_W=8.
- The selector stage imports the same constants.
- One natural sub-module, mxv_elem_counter: row/col counter with load, increment, last-column and last-element flags.

Test Plan:
- Reset then start, n_size=2, bytes 0x11,0x12,0x21,0x22,0xA1,0xA2 back-to-back → pushes with i_sel 0,0,1,1,8,8 and matching data, each 1 cycle after rx_valid; load_done on the cycle after the 0xA2 push.
- n_size=8, 72 bytes with random rx_valid gaps → exactly 8 pushes per i_sel 0..7 and 8 to i_sel 8; i_sel=15 and push_out=0 in every gap cycle.
- start with n_size=0, then n_size=9 → err_size pulses twice, busy stays 0, rx bytes produce no push.
- Assert reset after 5 of 12 bytes (n_size=3) → push_out=0, i_sel=15 at once; a fresh start with n_size=1 plus 2 bytes gives pushes to i_sel 0 then 8.
- start pulsed again mid-load with n_size=4 (original N=2) → ignored; the load completes with 6 pushes.
- MXV_LOAD_TIMEOUT_EN, TIMEOUT_CYC=16: n_size=2, send 3 bytes, then idle 16 cycles → err_timeout pulses, FSM back in IDLE, no load_done.
